// File: rtl/carry_increment_adder_pkg.sv
// Shared helpers for the carry-increment adder: group count and top-group width.
package carry_increment_adder_pkg;

    // Number of groups the operand is split into: ceil(n / block).
    function automatic int unsigned cia_num_groups(input int unsigned n, input int unsigned block);
        return (n + block - 1) / block;
    endfunction

    // Width of the most significant group; narrower than block when block does not divide n.
    function automatic int unsigned cia_last_width(input int unsigned n, input int unsigned block);
        return n - (cia_num_groups(n, block) - 1) * block;
    endfunction

endpackage

// File: rtl/cia_group.sv
// One carry-increment group: ripple sum with carry-in 0, then an incrementer that
// folds in the carry arriving from the group below.
module cia_group #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // Ripple-add a+b with carry-in 0, increment by cin, OR the two carries.
    always_comb begin : ripple_inc
        logic         c0;
        logic         ci;
        logic [W-1:0] s0;
        c0 = 1'b0;
        s0 = '0;
        for (int i = 0; i < int'(W); i++) begin
            s0[i] = a[i] ^ b[i] ^ c0;
            c0    = (a[i] & b[i]) | (c0 & (a[i] ^ b[i]));
        end
        ci  = cin;
        sum = '0;
        for (int i = 0; i < int'(W); i++) begin
            sum[i] = s0[i] ^ ci;
            ci     = s0[i] & ci;
        end
        // The pre-sum and the increment can never both carry out, so OR is exact.
        cout = c0 | ci;
    end

endmodule

// File: rtl/carry_increment_adder.sv
// Registered N-bit carry-increment adder: {cout, sum} = a + b + cin, one-cycle latency.
module carry_increment_adder
    import carry_increment_adder_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned BLOCK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         in_valid,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         out_valid
);

    localparam int unsigned NumGroups = cia_num_groups(N, BLOCK);

    logic [N-1:0]       sum_d;
    logic [N-1:0]       sum_q;
    logic               cout_q;
    logic               valid_q;
    logic [NumGroups:0] grp_carry;
    logic [BLOCK-1:0]   grp0_sum;
    logic               grp0_cout;

    assign grp_carry[0] = cin;

    // Group 0 is a plain ripple adder fed directly by cin.
    always_comb begin : grp0_ripple
        logic c;
        c        = grp_carry[0];
        grp0_sum = '0;
        for (int i = 0; i < int'(BLOCK); i++) begin
            grp0_sum[i] = a[i] ^ b[i] ^ c;
            c           = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        grp0_cout = c;
    end

    assign sum_d[BLOCK-1:0] = grp0_sum;
    assign grp_carry[1]     = grp0_cout;

    // Higher groups: precomputed sum, incremented by the carry from below.
    for (genvar g = 1; g < int'(NumGroups); g++) begin : gen_grp
        localparam int unsigned Lo = g * BLOCK;
        localparam int unsigned W  = ((N - Lo) < BLOCK) ? (N - Lo) : BLOCK;

        cia_group #(
            .W (W)
        ) u_grp (
            .a    (a[Lo +: W]),
            .b    (b[Lo +: W]),
            .cin  (grp_carry[g]),
            .sum  (sum_d[Lo +: W]),
            .cout (grp_carry[g+1])
        );
    end

    // Output register: load on in_valid, otherwise hold; out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= grp_carry[NumGroups];
            end
            valid_q <= in_valid;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_carry_increment_adder.sv
// Directed and randomized checks of carry_increment_adder across several N/BLOCK shapes.
module tb_carry_increment_adder;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    // N=16, BLOCK=4
    logic [15:0] a16, b16, s16;
    logic        c16, v16, co16, ov16;
    // N=8, BLOCK=4
    logic [7:0]  a8, b8, s8;
    logic        c8, v8, co8, ov8;
    // N=8, BLOCK=1 (per-bit increment chain)
    logic [7:0]  ae, be, se;
    logic        ce, ve, coe, ove;
    // N=32, BLOCK=4
    logic [31:0] a32, b32, s32;
    logic        c32, v32, co32, ov32;
    // N=4, BLOCK=4 (single ripple adder)
    logic [3:0]  a4, b4, s4;
    logic        c4, v4, co4, ov4;
    // N=13, BLOCK=5 (uneven top group)
    logic [12:0] a13, b13, s13;
    logic        c13, v13, co13, ov13;

    carry_increment_adder #(.N(16), .BLOCK(4)) u_d16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(c16), .in_valid(v16),
        .sum(s16), .cout(co16), .out_valid(ov16));
    carry_increment_adder #(.N(8), .BLOCK(4)) u_d8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(c8), .in_valid(v8),
        .sum(s8), .cout(co8), .out_valid(ov8));
    carry_increment_adder #(.N(8), .BLOCK(1)) u_de (
        .clk(clk), .rst_n(rst_n), .a(ae), .b(be), .cin(ce), .in_valid(ve),
        .sum(se), .cout(coe), .out_valid(ove));
    carry_increment_adder #(.N(32), .BLOCK(4)) u_d32 (
        .clk(clk), .rst_n(rst_n), .a(a32), .b(b32), .cin(c32), .in_valid(v32),
        .sum(s32), .cout(co32), .out_valid(ov32));
    carry_increment_adder #(.N(4), .BLOCK(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .cin(c4), .in_valid(v4),
        .sum(s4), .cout(co4), .out_valid(ov4));
    carry_increment_adder #(.N(13), .BLOCK(5)) u_d13 (
        .clk(clk), .rst_n(rst_n), .a(a13), .b(b13), .cin(c13), .in_valid(v13),
        .sum(s13), .cout(co13), .out_valid(ov13));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [13:0] ref13;
    logic [12:0] exp_s13;
    logic        exp_c13;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        {a16, b16, c16, v16} = '0;
        {a8, b8, c8, v8}     = '0;
        {ae, be, ce, ve}     = '0;
        {a32, b32, c32, v32} = '0;
        {a4, b4, c4, v4}     = '0;
        {a13, b13, c13, v13} = '0;

        // Reset state, with in_valid high to show reset wins.
        v16 = 1'b1;
        a16 = 16'h1234;
        repeat (2) tick();
        check("rst_sum16", s16, 16'h0);
        check("rst_cout16", co16, 1'b0);
        check("rst_ov16", ov16, 1'b0);
        check("rst_ov13", ov13, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        // Step 1: first vector on every shape.
        a16 = 16'hADC0; b16 = 16'hFE80; c16 = 1'b1; v16 = 1'b1;
        a8  = 8'h0E;    b8  = 8'h0B;    c8  = 1'b0; v8  = 1'b1;
        ae  = 8'hFF;    be  = 8'h00;    ce  = 1'b1; ve  = 1'b1;
        a32 = 32'hD47856ED; b32 = 32'hDCBE1597; c32 = 1'b1; v32 = 1'b1;
        a4  = 4'hA;     b4  = 4'h7;     c4  = 1'b1; v4  = 1'b1;
        tick();
        check("s1_sum16", s16, 16'hAC41);
        check("s1_cout16", co16, 1'b1);
        check("s1_ov16", ov16, 1'b1);
        check("s1_sum8", s8, 8'h19);
        check("s1_cout8", co8, 1'b0);
        check("s1_sum8b1", se, 8'h00);
        check("s1_cout8b1", coe, 1'b1);
        check("s1_sum32", s32, 32'hB1366C85);
        check("s1_cout32", co32, 1'b1);
        check("s1_sum4", s4, 4'h2);
        check("s1_cout4", co4, 1'b1);

        @(negedge clk);
        a16 = 16'h3A9A; b16 = 16'hE544; c16 = 1'b0;
        a8  = 8'h69;    b8  = 8'hD7;    c8  = 1'b0;
        ae  = 8'h69;    be  = 8'hD7;    ce  = 1'b0;
        v32 = 1'b0;     a32 = 32'h1;    b32 = 32'h1;
        tick();
        check("s2_sum16", s16, 16'h1FDE);
        check("s2_cout16", co16, 1'b1);
        check("s2_sum8", s8, 8'h40);
        check("s2_cout8", co8, 1'b1);
        check("s2_sum8b1", se, 8'h40);
        check("s2_cout8b1", coe, 1'b1);
        check("s2_hold32", s32, 32'hB1366C85);
        check("s2_ov32", ov32, 1'b0);

        // All-ones plus carry-in ripples through every group.
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1;
        tick();
        check("s3_sum16", s16, 16'h0000);
        check("s3_cout16", co16, 1'b1);

        @(negedge clk);
        a16 = 16'h1234; b16 = 16'h1111; c16 = 1'b0;
        tick();
        check("s4_sum16", s16, 16'h2345);
        check("s4_cout16", co16, 1'b0);

        // Drop in_valid: hold result, out_valid falls.
        @(negedge clk);
        v16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
        tick();
        check("hold_sum16", s16, 16'h2345);
        check("hold_cout16", co16, 1'b0);
        check("hold_ov16", ov16, 1'b0);

        // Reload, then reset between edges clears outputs without a clock edge.
        @(negedge clk);
        v16 = 1'b1;
        tick();
        check("reload_cout16", co16, 1'b1);
        check("reload_ov16", ov16, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sum16", s16, 16'h0);
        check("async_cout16", co16, 1'b0);
        check("async_ov16", ov16, 1'b0);
        @(negedge clk);
        v16   = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_ov16", ov16, 1'b0);
        check("post_rst_sum16", s16, 16'h0);
        @(negedge clk);
        a16 = 16'h0001; b16 = 16'h0001; c16 = 1'b0; v16 = 1'b1;
        tick();
        check("post_rst_load16", s16, 16'h0002);
        check("post_rst_ov16b", ov16, 1'b1);

        // Randomized run on the uneven N=13, BLOCK=5 shape.
        exp_s13 = '0;
        exp_c13 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a13 = 13'($urandom);
            b13 = 13'($urandom);
            c13 = 1'($urandom);
            v13 = ($urandom_range(0, 3) != 0);
            if (v13) begin
                ref13   = {1'b0, a13} + {1'b0, b13} + {13'b0, c13};
                exp_s13 = ref13[12:0];
                exp_c13 = ref13[13];
            end
            tick();
            check("rnd_sum13", s13, exp_s13);
            check("rnd_cout13", co13, exp_c13);
            check("rnd_ov13", ov13, v13);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
